muldiv_seq_ctrl: RTL

Sequencer for the RV32M multiply/divide operations that cannot complete in one Execute cycle. It accepts an M-extension op from the Execute stage and runs an iterative radix-2 shift-add multiply or restoring divide. It holds the pipeline via stall_o until the result is ready, then presents the result and destination register for the EX/MEM register to capture.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_core_iter.sv | 79 +++++++
 rtl/muldiv_seq_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: FSM states,
// funct3 op encodings and op-classification helpers.
// No ports; imported by muldiv_core_iter and muldiv_seq_ctrl.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   function automatic logic is_div(input logic [2:0] op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(input logic [2:0] op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

   function automatic logic takes_high(input logic [2:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

endpackage

// File: rtl/muldiv_core_iter.sv
// Iterative unsigned datapath: radix-2 shift-add multiply / restoring divide.
// Ports: start loads magnitudes + mode, step runs one iteration and decrements
// the counter, last_iter flags the final step; prod/quot/rem are raw magnitudes.
module muldiv_core_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic              div_mode,
   input  logic [XLEN-1:0]   a_abs,
   input  logic [XLEN-1:0]   b_abs,
   output logic [2*XLEN-1:0] prod,
   output logic [XLEN-1:0]   quot,
   output logic [XLEN-1:0]   rem,
   output logic              last_iter
);

   logic              div_q;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] prod_q;
   logic [XLEN-1:0]   quot_q;
   logic [XLEN-1:0]   rem_q;

   // Multiply: low half starts as the multiplier and shifts out LSB-first
   // while partial sums enter from the top (carry kept in mul_sum).
   logic [XLEN:0] mul_sum;
   // Divide: XLEN+1-bit working remainder; the MSB of trial is the borrow.
   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
   assign shifted = {rem_q, quot_q[XLEN-1]};
   assign trial   = shifted - {1'b0, b_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= 1'b0;
         cnt    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         quot_q <= '0;
         rem_q  <= '0;
      end else if (start) begin
         div_q  <= div_mode;
         cnt    <= CNT_W'(XLEN);
         b_q    <= b_abs;
         prod_q <= {{XLEN{1'b0}}, a_abs};
         quot_q <= a_abs;
         rem_q  <= '0;
      end else if (step) begin
         cnt <= cnt - 1'b1;
         if (div_q) begin
            // Restore when the trial subtraction borrows; the shifted value
            // is then below the divisor, so its top bit is always zero.
            if (trial[XLEN]) begin
               rem_q  <= shifted[XLEN-1:0];
               quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end else begin
               rem_q  <= trial[XLEN-1:0];
               quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end
         end else begin
            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
         end
      end
   end

   assign prod      = prod_q;
   assign quot      = quot_q;
   assign rem       = rem_q;
   assign last_iter = (cnt == CNT_W'(1));

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// RV32M multi-cycle sequencer: accepts an M op from Execute, stalls the
// pipeline while muldiv_core_iter iterates, then pulses done_o with result/rd.
// Ports: valid_i/op_i/rs1_i/rs2_i/rd_i in, flush_i kills, stall_o/busy_o/done_o,
// result_o/rd_o (held between completions). Optional macro: MULDIV_FAST_MUL_EN.
module muldiv_seq_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o,
   output logic            busy_o
);

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nxt;
   logic              accept, commit;
   logic              sa_in, sb_in;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic              fast;
   logic [XLEN-1:0]   fast_res;

   logic [2:0]        op_q;
   logic [4:0]        rd_q, rd_hold_q;
   logic              sign_a_q, sign_b_q, special_q;
   logic [XLEN-1:0]   special_res_q, result_q;

   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quot, rem, q_s, r_s, calc_res, final_res;
   logic              last_iter;

   assign accept = valid_i & ~flush_i & (state == IDLE);
   // A completion is committed only if it survives a same-cycle flush.
   assign commit = (state == DONE) & ~flush_i;

   assign sa_in = is_signed_a(op_i) & rs1_i[XLEN-1];
   assign sb_in = is_signed_b(op_i) & rs2_i[XLEN-1];
   assign a_abs = sa_in ? -rs1_i : rs1_i;
   assign b_abs = sb_in ? -rs2_i : rs2_i;

`ifdef MULDIV_FAST_MUL_EN
   // Operands extended to 2*XLEN per their signedness; the truncated
   // product is exact for all three signed/unsigned combinations.
   logic [2*XLEN-1:0] a_wide, b_wide, fprod;
   assign a_wide = {{XLEN{sa_in}}, rs1_i};
   assign b_wide = {{XLEN{sb_in}}, rs2_i};
   assign fprod  = a_wide * b_wide;
`endif

   // Results that bypass iteration are computed at accept and parked in
   // special_res_q until the DONE cycle.
   always_comb begin
      fast     = 1'b0;
      fast_res = '0;
      if (is_div(op_i) && (rs2_i == '0)) begin
         fast     = 1'b1;
         fast_res = is_rem(op_i) ? rs1_i : '1;
      end else if (is_div(op_i) && is_signed_b(op_i) && (rs1_i == MIN_INT) && (rs2_i == '1)) begin
         fast     = 1'b1;
         fast_res = is_rem(op_i) ? '0 : MIN_INT;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!is_div(op_i)) begin
         fast     = 1'b1;
         fast_res = takes_high(op_i) ? fprod[2*XLEN-1:XLEN] : fprod[XLEN-1:0];
      end
`endif
   end

   muldiv_core_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (accept & ~fast),
      .step      (state == CALC),
      .div_mode  (is_div(op_i)),
      .a_abs     (a_abs),
      .b_abs     (b_abs),
      .prod      (prod),
      .quot      (quot),
      .rem       (rem),
      .last_iter (last_iter)
   );

   // Sign correction: quotient/product negative when signs differ,
   // remainder follows the dividend.
   assign prod_s    = (sign_a_q ^ sign_b_q) ? -prod : prod;
   assign q_s       = (sign_a_q ^ sign_b_q) ? -quot : quot;
   assign r_s       = sign_a_q ? -rem : rem;
   assign calc_res  = is_div(op_q) ? (is_rem(op_q) ? r_s : q_s)
                    : (takes_high(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);
   assign final_res = special_q ? special_res_q : calc_res;

   assign result_o  = commit ? final_res : result_q;
   assign rd_o      = commit ? rd_q : rd_hold_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      busy_o    = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept) begin
               stall_o   = 1'b1;
               state_nxt = fast ? DONE : CALC;
            end
         end
         CALC: begin
            stall_o = 1'b1;
            if (flush_i)        state_nxt = IDLE;
            else if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            done_o    = ~flush_i;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q          <= '0;
         rd_q          <= '0;
         rd_hold_q     <= '0;
         sign_a_q      <= 1'b0;
         sign_b_q      <= 1'b0;
         special_q     <= 1'b0;
         special_res_q <= '0;
         result_q      <= '0;
      end else begin
         if (accept) begin
            op_q          <= op_i;
            rd_q          <= rd_i;
            sign_a_q      <= sa_in;
            sign_b_q      <= sb_in;
            special_q     <= fast;
            special_res_q <= fast_res;
         end
         if (commit) begin
            result_q  <= final_res;
            rd_hold_q <= rd_q;
         end
      end
   end

endmodule
